// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line fetch path.
package sprite_pkg;

    localparam int ICON_WORDS = 2;
    localparam logic [9:0] SPRITE_OFFSCREEN_X = 10'd640;
    localparam int PIX_W = 4;
    localparam int ICON_IDX_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [ICON_IDX_W-1:0] icon;
        logic                  word;
    } fetch_tag_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_tag_pipe.sv
// Delays the {valid, icon, word} read tag so it lines up with returning memory data.
module fetch_tag_pipe
    import sprite_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       clear,
    input  fetch_tag_t tag_in,
    output fetch_tag_t tag_out,
    output logic       pending
);

    fetch_tag_t stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tag_out = stage_q[DEPTH-1];

    // Tags still in flight behind the output stage.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) pending = pending | stage_q[i].valid;
    end

endmodule

// File: rtl/sprite_line_fetch.sv
// Per-scanline pattern fetch: reads two words per icon and strobes them to the icons.
// Optional SPRITE_SKIP_EN adds icon_x and skips icons parked at x == 640.
module sprite_line_fetch
    import sprite_pkg::*;
#(
    parameter int NUM_ICONS   = 8,
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 12
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            line_start,
    input  logic [NUM_ICONS*ADDR_W-1:0]     icon_addr,
`ifdef SPRITE_SKIP_EN
    input  logic [NUM_ICONS*10-1:0]         icon_x,
`endif
    output logic [ADDR_W-1:0]               mem_addr,
    output logic                            mem_rd,
    input  logic [31:0]                     mem_data,
    output logic [NUM_ICONS*ICON_WORDS-1:0] icon_ds,
    output logic [31:0]                     icon_data,
    output logic                            busy,
    output logic                            done
);

    // state | meaning
    // IDLE  | waiting for line_start
    // ISSUE | one read per cycle, icon-major, left word first
    // DRAIN | waiting for the last tag to retire

    fetch_state_t              state_q, state_d;
    logic [NUM_ICONS*ADDR_W-1:0] addr_q;
    logic [NUM_ICONS-1:0]      skip_q, skip_new;
    logic [ICON_IDX_W-1:0]     icon_q, icon_d;
    logic                      word_q, word_d;
    logic                      done_q, done_d;
    logic [31:0]               data_q;
    logic [5:0]                first_icon, next_icon;
    fetch_tag_t                tag_in, tag_out;
    logic                      pending;

`ifdef SPRITE_SKIP_EN
    always_comb begin
        for (int i = 0; i < NUM_ICONS; i++)
            skip_new[i] = (icon_x[i*10 +: 10] == SPRITE_OFFSCREEN_X);
    end
`else
    assign skip_new = '0;
`endif

    // Lowest non-skipped icon at or above start; NUM_ICONS when none remain.
    function automatic logic [5:0] find_from(input logic [NUM_ICONS-1:0] skip,
                                             input logic [5:0] start);
        logic [5:0] r;
        r = 6'(NUM_ICONS);
        for (int i = NUM_ICONS - 1; i >= 0; i--)
            if (6'(i) >= start && !skip[i]) r = 6'(i);
        return r;
    endfunction

    assign first_icon = find_from(skip_new, 6'd0);
    assign next_icon  = find_from(skip_q, {1'b0, icon_q} + 6'd1);

    always_comb begin
        state_d = state_q;
        icon_d  = icon_q;
        word_d  = word_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (line_start) begin
                    if (first_icon == 6'(NUM_ICONS)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        icon_d  = first_icon[ICON_IDX_W-1:0];
                        word_d  = 1'b0;
                    end
                end
            end
            ISSUE: begin
                if (!word_q) begin
                    word_d = 1'b1;
                end else if (next_icon == 6'(NUM_ICONS)) begin
                    state_d = DRAIN;
                end else begin
                    icon_d = next_icon[ICON_IDX_W-1:0];
                    word_d = 1'b0;
                end
            end
            DRAIN: begin
                if (!pending) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            icon_q  <= '0;
            word_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            skip_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            icon_q  <= icon_d;
            word_q  <= word_d;
            done_q  <= done_d;
            if (state_q == IDLE && line_start) begin
                addr_q <= icon_addr;
                skip_q <= skip_new;
            end
            if (tag_out.valid) data_q <= mem_data;
        end
    end

    assign mem_rd   = (state_q == ISSUE);
    assign mem_addr = mem_rd ? {addr_q[int'(icon_q)*ADDR_W + 3 +: ADDR_W-3], word_q, 2'b00}
                             : '0;

    always_comb begin
        tag_in       = '0;
        tag_in.valid = mem_rd;
        tag_in.icon  = icon_q;
        tag_in.word  = word_q;
    end

    fetch_tag_pipe #(.DEPTH(MEM_LATENCY)) u_tag_pipe (
        .clk     (clk),
        .clear   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out),
        .pending (pending)
    );

    always_comb begin
        icon_ds = '0;
        if (tag_out.valid)
            icon_ds[ICON_WORDS*int'(tag_out.icon) + int'(tag_out.word)] = 1'b1;
    end

    assign icon_data = tag_out.valid ? mem_data : data_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
